// File: rtl/riscv_stall_ctrl_pkg.sv
// Stall controller shared types: FSM state encodings, register index width.
// Imported by the stall controller and the hazard detector.
package riscv_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    STALL_RUN      = 2'd0,
    STALL_MEM_WAIT = 2'd1,
    STALL_MC_WAIT  = 2'd2
  } stall_state_e;

endpackage

// File: rtl/riscv_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX destination.
// In: ID rs1/rs2 + used flags, EX rd + load flag. Out: o_load_use.
module riscv_hazard_detect
  import riscv_stall_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_is_load,
  output logic                  o_load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
  assign rs2_hit = i_id_rs2_used & (i_id_rs2 == i_ex_rd);

  // x0 is never a real producer
  assign o_load_use = i_ex_is_load & (i_ex_rd != '0)
                    & (rs1_hit | rs2_hit);

endmodule

// File: rtl/riscv_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, branch, mem wait, MUL/DIV.
// In: hazard/mem/branch/mc status. Out: per-register stalls, flushes, err, busy.
module riscv_stall_ctrl
  import riscv_stall_ctrl_pkg::*;
#(
  parameter int MC_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_is_load,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_ex_mc_start,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ack,
  output logic                  o_stall_pc,
  output logic                  o_stall_if_id,
  output logic                  o_stall_id_ex,
  output logic                  o_stall_ex_mem,
  output logic                  o_stall_mem_wb,
  output logic                  o_flush_if_id,
  output logic                  o_flush_id_ex,
  output logic                  o_flush_ex_mem,
  output logic                  o_mem_err,
  output logic                  o_busy
);

  localparam int MC_W = $clog2(MC_LATENCY);
  localparam int TO_W = $clog2(MEM_TIMEOUT) + 1;

  stall_state_e    state_q, state_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            load_use;
  logic            mem_hold;
  logic            run_rules;

  riscv_hazard_detect u_hazard (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_ex_rd       (i_ex_rd),
    .i_ex_is_load  (i_ex_is_load),
    .o_load_use    (load_use)
  );

  assign mem_hold = i_mem_req & ~i_mem_ack;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= STALL_RUN;
      mc_cnt_q <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mc_cnt_d       = mc_cnt_q;
    to_cnt_d       = to_cnt_q;
    err_d          = 1'b0;
    run_rules      = 1'b0;
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_stall_ex_mem = 1'b0;
    o_stall_mem_wb = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    o_flush_ex_mem = 1'b0;

    unique case (state_q)
      STALL_RUN: run_rules = 1'b1;
      STALL_MEM_WAIT: begin
        if (i_mem_ack) begin
          // ack frees the pipe now; let new hazards act this cycle
          to_cnt_d  = '0;
          state_d   = STALL_RUN;
          run_rules = 1'b1;
        end else if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
          to_cnt_d = '0;
          err_d    = 1'b1;
          state_d  = STALL_RUN;
        end else begin
          o_stall_pc     = 1'b1;
          o_stall_if_id  = 1'b1;
          o_stall_id_ex  = 1'b1;
          o_stall_ex_mem = 1'b1;
          o_stall_mem_wb = 1'b1;
          to_cnt_d       = to_cnt_q + 1'b1;
        end
      end
      STALL_MC_WAIT: begin
        mc_cnt_d = (mc_cnt_q != '0) ? mc_cnt_q - 1'b1 : '0;
        if (mc_cnt_q != '0) begin
          o_stall_pc    = 1'b1;
          o_stall_if_id = 1'b1;
          o_stall_id_ex = 1'b1;
          if (mem_hold) begin
            o_stall_ex_mem = 1'b1;
            o_stall_mem_wb = 1'b1;
          end else begin
            o_flush_ex_mem = 1'b1;
          end
        end else if (mem_hold) begin
          o_stall_pc     = 1'b1;
          o_stall_if_id  = 1'b1;
          o_stall_id_ex  = 1'b1;
          o_stall_ex_mem = 1'b1;
          o_stall_mem_wb = 1'b1;
        end
        // leave on the last hold cycle so the front end frees
        // exactly MC_LATENCY cycles after the start pulse
        if (mc_cnt_q <= MC_W'(1)) begin
          if (mem_hold) begin
            state_d  = STALL_MEM_WAIT;
            to_cnt_d = TO_W'(1);
          end else begin
            state_d = STALL_RUN;
          end
        end
      end
      default: state_d = STALL_RUN;
    endcase

    if (run_rules) begin
      if (mem_hold) begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_stall_id_ex  = 1'b1;
        o_stall_ex_mem = 1'b1;
        o_stall_mem_wb = 1'b1;
        to_cnt_d       = TO_W'(1);
        state_d        = STALL_MEM_WAIT;
      end else if (i_ex_mc_start) begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_stall_id_ex  = 1'b1;
        o_flush_ex_mem = 1'b1;
        mc_cnt_d       = MC_W'(MC_LATENCY - 1);
        state_d        = STALL_MC_WAIT;
      end else if (i_ex_branch_taken) begin
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end else if (load_use) begin
        o_stall_pc    = 1'b1;
        o_stall_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end
    end
  end

  assign o_mem_err = err_q;
  assign o_busy    = (state_q != STALL_RUN);

endmodule
